// File: rtl/soundweb_pkg.sv
// ============================================================================
// Module      : soundweb_pkg
// Description : Shared Soundweb framing constants, field indices and helpers.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package soundweb_pkg;

    localparam logic [7:0] STX        = 8'h02;
    localparam logic [7:0] ETX        = 8'h03;
    localparam logic [7:0] ESC        = 8'h1B;
    localparam logic [7:0] ACK        = 8'h06;
    localparam logic [7:0] NAK        = 8'h15;
    localparam logic [7:0] ESC_OFFSET = 8'h80;

    localparam int BODY_BYTES = 13;
    localparam int CNT_W      = 4;

    typedef logic [CNT_W-1:0] count_t;

    localparam count_t CNT_BODY = count_t'(BODY_BYTES);
    localparam count_t CNT_FULL = count_t'(BODY_BYTES + 1);

    localparam int COMMAND   = 0;
    localparam int ADDRESS_0 = 1;
    localparam int ADDRESS_1 = 2;
    localparam int ADDRESS_2 = 3;
    localparam int ADDRESS_3 = 4;
    localparam int ADDRESS_4 = 5;
    localparam int ADDRESS_5 = 6;
    localparam int SV_0      = 7;
    localparam int SV_1      = 8;
    localparam int DATA_0    = 9;
    localparam int DATA_1    = 10;
    localparam int DATA_2    = 11;
    localparam int DATA_3    = 12;

    function automatic logic is_reserved_byte(input logic [7:0] b);
        return (b == STX) || (b == ETX) || (b == ACK) || (b == NAK) || (b == ESC);
    endfunction

endpackage

`default_nettype wire

// File: rtl/soundweb_if.sv
// ============================================================================
// Module      : soundweb_if
// Description : Byte-stream input and decoded-field output bundle.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface soundweb_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] command;
    logic [7:0] address_0;
    logic [7:0] address_1;
    logic [7:0] address_2;
    logic [7:0] address_3;
    logic [7:0] address_4;
    logic [7:0] address_5;
    logic [7:0] sv_0;
    logic [7:0] sv_1;
    logic [7:0] data_0;
    logic [7:0] data_1;
    logic [7:0] data_2;
    logic [7:0] data_3;
    logic       packet_valid;
    logic       checksum_error;
    logic       framing_error;
    logic       ack_rx;
    logic       nak_rx;

    modport master (
        output rx_data, rx_valid,
        input  command, address_0, address_1, address_2, address_3, address_4,
               address_5, sv_0, sv_1, data_0, data_1, data_2, data_3,
               packet_valid, checksum_error, framing_error, ack_rx, nak_rx
    );

    modport slave (
        input  rx_data, rx_valid,
        output command, address_0, address_1, address_2, address_3, address_4,
               address_5, sv_0, sv_1, data_0, data_1, data_2, data_3,
               packet_valid, checksum_error, framing_error, ack_rx, nak_rx
    );

endinterface

`default_nettype wire

// File: rtl/soundweb_decoder.sv
// ============================================================================
// Module      : soundweb_decoder
// Description : STX/ETX frame decoder with ESC unstuffing and XOR checksum.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module soundweb_decoder
    import soundweb_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   reset,
    soundweb_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BODY   = 2'd1,
        S_ESCAPE = 2'd2
    } state_e;

    state_e     state_q;
    count_t     count_q;
    logic [7:0] xor_q;
    logic [7:0] cks_q;
    logic [7:0] shadow_q [BODY_BYTES];
    logic [7:0] field_q  [BODY_BYTES];
    logic       packet_valid_q;
    logic       checksum_error_q;
    logic       framing_error_q;
    logic       ack_q;
    logic       nak_q;

    logic [7:0] w_unesc;
    logic [7:0] w_byte;
    logic       w_store;

    // Unescaped body bytes and escaped reserved values share one store path.
    assign w_unesc = bus.rx_data - ESC_OFFSET;
    assign w_byte  = (state_q == S_ESCAPE) ? w_unesc : bus.rx_data;
    assign w_store = ((state_q == S_BODY)   && !is_reserved_byte(bus.rx_data)) ||
                     ((state_q == S_ESCAPE) &&  is_reserved_byte(w_unesc));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            count_q          <= '0;
            xor_q            <= '0;
            cks_q            <= '0;
            packet_valid_q   <= 1'b0;
            checksum_error_q <= 1'b0;
            framing_error_q  <= 1'b0;
            ack_q            <= 1'b0;
            nak_q            <= 1'b0;
            for (int i = 0; i < BODY_BYTES; i++) begin
                shadow_q[i] <= '0;
                field_q[i]  <= '0;
            end
        end else begin
            packet_valid_q   <= 1'b0;
            checksum_error_q <= 1'b0;
            framing_error_q  <= 1'b0;
            ack_q            <= 1'b0;
            nak_q            <= 1'b0;
            if (bus.rx_valid) begin
                if (w_store) begin
                    state_q <= S_BODY;
                    if (count_q < CNT_BODY) begin
                        shadow_q[count_q] <= w_byte;
                        xor_q             <= xor_q ^ w_byte;
                        count_q           <= count_q + 1'b1;
                    end else if (count_q == CNT_BODY) begin
                        cks_q   <= w_byte;
                        count_q <= count_q + 1'b1;
                    end else begin
                        framing_error_q <= 1'b1;
                        state_q         <= S_IDLE;
                    end
                end else begin
                    case (state_q)
                        S_IDLE: begin
                            if (bus.rx_data == STX) begin
                                state_q <= S_BODY;
                                count_q <= '0;
                                xor_q   <= '0;
                            end else if (bus.rx_data == ACK) begin
                                ack_q <= 1'b1;
                            end else if (bus.rx_data == NAK) begin
                                nak_q <= 1'b1;
                            end
                        end
                        S_BODY: begin
                            if (bus.rx_data == ESC) begin
                                state_q <= S_ESCAPE;
                            end else if (bus.rx_data == STX) begin
                                framing_error_q <= 1'b1;
                                count_q         <= '0;
                                xor_q           <= '0;
                            end else if (bus.rx_data == ETX) begin
                                state_q <= S_IDLE;
                                if (count_q != CNT_FULL) begin
                                    framing_error_q <= 1'b1;
                                end else if (cks_q == xor_q) begin
                                    field_q        <= shadow_q;
                                    packet_valid_q <= 1'b1;
                                end else begin
                                    checksum_error_q <= 1'b1;
                                end
                            end else begin
                                // Only ACK/NAK remain: not allowed inside a frame.
                                framing_error_q <= 1'b1;
                                state_q         <= S_IDLE;
                            end
                        end
                        default: begin
                            framing_error_q <= 1'b1;
                            state_q         <= S_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.command        = field_q[COMMAND];
    assign bus.address_0      = field_q[ADDRESS_0];
    assign bus.address_1      = field_q[ADDRESS_1];
    assign bus.address_2      = field_q[ADDRESS_2];
    assign bus.address_3      = field_q[ADDRESS_3];
    assign bus.address_4      = field_q[ADDRESS_4];
    assign bus.address_5      = field_q[ADDRESS_5];
    assign bus.sv_0           = field_q[SV_0];
    assign bus.sv_1           = field_q[SV_1];
    assign bus.data_0         = field_q[DATA_0];
    assign bus.data_1         = field_q[DATA_1];
    assign bus.data_2         = field_q[DATA_2];
    assign bus.data_3         = field_q[DATA_3];
    assign bus.packet_valid   = packet_valid_q;
    assign bus.checksum_error = checksum_error_q;
    assign bus.framing_error  = framing_error_q;
    assign bus.ack_rx         = ack_q;
    assign bus.nak_rx         = nak_q;

endmodule

`default_nettype wire

// File: tb/tb_soundweb_decoder.sv
// ============================================================================
// Module      : tb_soundweb_decoder
// Description : Directed and random frame stimulus against a queue-based model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_soundweb_decoder;

    typedef byte unsigned bq_t[$];

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_en  = 1'b0;

    soundweb_if sw();

    soundweb_decoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sw.slave)
    );

    always #5 clk = ~clk;

    // Model state: frame contents kept as a queue of decoded bytes.
    bit           m_in;
    bit           m_esc;
    byte unsigned m_q[$];
    logic [7:0]   m_f[13];
    logic         m_pv, m_ce, m_fe, m_ack, m_nak;

    function automatic bit rsv(input byte unsigned x);
        return x == 8'h02 || x == 8'h03 || x == 8'h06 || x == 8'h15 || x == 8'h1B;
    endfunction

    task automatic chk(input string name, input logic [103:0] act, input logic [103:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task m_store(input byte unsigned d);
        if (m_q.size() < 14) m_q.push_back(d);
        else begin
            m_fe = 1'b1;
            m_in = 1'b0;
        end
    endtask

    always @(posedge clk) begin : model
        byte unsigned b, d, x;
        m_pv = 0; m_ce = 0; m_fe = 0; m_ack = 0; m_nak = 0;
        if (reset) begin
            m_in = 0; m_esc = 0; m_q.delete();
            for (int i = 0; i < 13; i++) m_f[i] = 8'h00;
        end else if (sw.rx_valid) begin
            b = sw.rx_data;
            if (!m_in) begin
                if (b == 8'h02) begin m_in = 1; m_esc = 0; m_q.delete(); end
                else if (b == 8'h06) m_ack = 1;
                else if (b == 8'h15) m_nak = 1;
            end else if (m_esc) begin
                m_esc = 0;
                d = b - 8'h80;
                if (rsv(d)) m_store(d);
                else begin m_fe = 1; m_in = 0; end
            end else if (b == 8'h1B) begin
                m_esc = 1;
            end else if (b == 8'h02) begin
                m_fe = 1; m_q.delete();
            end else if (b == 8'h03) begin
                m_in = 0;
                if (m_q.size() == 14) begin
                    x = 0;
                    for (int i = 0; i < 13; i++) x ^= m_q[i];
                    if (x == m_q[13]) begin
                        for (int i = 0; i < 13; i++) m_f[i] = m_q[i];
                        m_pv = 1;
                    end else m_ce = 1;
                end else m_fe = 1;
            end else if (b == 8'h06 || b == 8'h15) begin
                m_fe = 1; m_in = 0;
            end else begin
                m_store(b);
            end
        end
    end

    function automatic logic [103:0] model_fields();
        logic [103:0] v;
        for (int i = 0; i < 13; i++) v[103-8*i -: 8] = m_f[i];
        return v;
    endfunction

    wire logic [103:0] w_dut_fields = {sw.command, sw.address_0, sw.address_1, sw.address_2,
                                       sw.address_3, sw.address_4, sw.address_5, sw.sv_0,
                                       sw.sv_1, sw.data_0, sw.data_1, sw.data_2, sw.data_3};
    wire logic [4:0]   w_dut_pulses = {sw.packet_valid, sw.checksum_error, sw.framing_error,
                                       sw.ack_rx, sw.nak_rx};

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pulses", {99'd0, w_dut_pulses}, {99'd0, m_pv, m_ce, m_fe, m_ack, m_nak});
            chk("fields", w_dut_fields, model_fields());
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input byte unsigned b);
        sw.rx_data  = b;
        sw.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        sw.rx_valid = 1'b0;
        sw.rx_data  = 8'($urandom);
    endtask

    task automatic send_seq(input bq_t f, input int gap);
        for (int i = 0; i < f.size(); i++) begin
            if (i > 0) idle(gap);
            send(f[i]);
        end
    endtask

    bq_t          plain, bad, esc_f, f;
    byte unsigned bb[14];
    byte unsigned rs[5];
    byte unsigned x, t;
    int           mode;

    initial begin
        sw.rx_data  = 8'h00;
        sw.rx_valid = 1'b0;
        rs = '{8'h02, 8'h03, 8'h06, 8'h15, 8'h1B};
        plain = '{8'h02, 8'h8D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h10, 8'h9D, 8'h03};
        bad = plain;
        bad[14] = 8'h9C;
        esc_f = '{8'h02, 8'h88, 8'h00, 8'h01, 8'h1B, 8'h82, 8'h1B, 8'h83, 8'h04, 8'h05,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h88, 8'h03};

        @(posedge clk);
        #1;
        chk_en = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("reset_fields", w_dut_fields, 104'd0);
        chk("reset_pulses", {99'd0, w_dut_pulses}, 104'd0);

        send_seq(plain, 0);
        chk("plain_pv", {103'd0, sw.packet_valid}, 104'd1);
        chk("plain_cmd", {96'd0, sw.command}, {96'd0, 8'h8D});
        chk("plain_d3", {96'd0, sw.data_3}, {96'd0, 8'h10});
        chk("model_plain_cmd", {96'd0, m_f[0]}, {96'd0, 8'h8D});

        send_seq(bad, 0);
        chk("bad_ce", {103'd0, sw.checksum_error}, 104'd1);
        chk("bad_no_pv", {103'd0, sw.packet_valid}, 104'd0);
        chk("bad_hold_cmd", {96'd0, sw.command}, {96'd0, 8'h8D});

        send_seq(esc_f, 0);
        chk("esc_pv", {103'd0, sw.packet_valid}, 104'd1);
        chk("esc_fields", w_dut_fields,
            {8'h88, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00, 8'h00,
             8'h00, 8'h00, 8'h01, 8'h00});
        chk("model_esc_a5", {96'd0, m_f[6]}, {96'd0, 8'h05});

        send_seq('{8'h02, 8'h8D, 8'h03}, 0);
        chk("short_fe", {103'd0, sw.framing_error}, 104'd1);
        send_seq(plain, 0);
        chk("after_short_pv", {103'd0, sw.packet_valid}, 104'd1);

        send_seq('{8'h02, 8'h8D, 8'h1B, 8'h41}, 0);
        chk("badesc_fe", {103'd0, sw.framing_error}, 104'd1);
        send_seq(esc_f, 0);
        chk("after_badesc_a3", {96'd0, sw.address_3}, {96'd0, 8'h03});

        send_seq('{8'h02, 8'h8D, 8'h00, 8'h02}, 0);
        chk("stx_mid_fe", {103'd0, sw.framing_error}, 104'd1);
        send_seq(plain[1:$], 0);
        chk("stx_mid_pv", {103'd0, sw.packet_valid}, 104'd1);
        chk("stx_mid_cmd", {96'd0, sw.command}, {96'd0, 8'h8D});

        send(8'h06);
        chk("ack", {99'd0, w_dut_pulses}, {99'd0, 5'b00010});
        send(8'h15);
        chk("nak", {99'd0, w_dut_pulses}, {99'd0, 5'b00001});
        send(8'h55);
        chk("idle_other", {99'd0, w_dut_pulses}, 104'd0);

        send_seq(esc_f, 3);
        chk("gap_pv", {103'd0, sw.packet_valid}, 104'd1);
        chk("gap_d2", {96'd0, sw.data_2}, {96'd0, 8'h01});

        send_seq(plain[0:5], 0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("midreset_fields", w_dut_fields, 104'd0);
        send_seq(plain, 0);
        chk("midreset_pv", {103'd0, sw.packet_valid}, 104'd1);

        for (int it = 0; it < 200; it++) begin
            mode = $urandom_range(0, 10);
            x = 0;
            for (int i = 0; i < 13; i++) begin
                if ($urandom_range(0, 3) == 0) bb[i] = rs[$urandom_range(0, 4)];
                else bb[i] = 8'($urandom);
                x ^= bb[i];
            end
            if (mode == 6) begin
                t = 8'h01;
                t = t << $urandom_range(0, 7);
                x ^= t;
            end
            bb[13] = x;
            f.delete();
            f.push_back(8'h02);
            for (int i = 0; i < 14; i++) begin
                if (rsv(bb[i])) begin
                    f.push_back(8'h1B);
                    f.push_back(bb[i] + 8'h80);
                end else f.push_back(bb[i]);
            end
            f.push_back(8'h03);
            if (mode == 7) begin
                repeat ($urandom_range(1, 3)) f.delete(f.size() - 2);
            end else if (mode == 8) begin
                f.delete();
                repeat ($urandom_range(1, 8)) begin
                    if ($urandom_range(0, 1) == 0) f.push_back(rs[$urandom_range(0, 4)]);
                    else f.push_back(8'h80 + 8'($urandom_range(0, 31)));
                end
            end else if (mode == 9) begin
                f.insert($urandom_range(1, f.size() - 1), 8'($urandom));
            end
            send_seq(f, $urandom_range(0, 2));
            idle($urandom_range(0, 2));
        end

        idle(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/soundweb_decoder.md
Name: soundweb_decoder

Overview:
- Receive-side counterpart of the Soundweb packet encoder. Consumes a serial byte stream, one byte per `rx_valid` strobe, and finds STX-delimited frames.
- Removes ESC byte-stuffing, then captures command, 6 address bytes, 2 SV bytes and 4 data bytes, and verifies the XOR checksum and ETX.
- Presents the decoded fields in parallel with a one-cycle valid pulse. Standalone ACK and NAK bytes are flagged as pulses.
- Sits between the UART receiver and the control/message logic.

Parameters:
- STX, 8'h02, start-of-frame byte
- ETX, 8'h03, end-of-frame byte
- ESC, 8'h1B, escape byte; the following byte carries the value + 8'h80
- ACK, 8'h06, standalone acknowledge
- NAK, 8'h15, standalone negative acknowledge
- BODY_BYTES, 13, decoded bytes before the checksum (command + 6 address + 2 SV + 4 data)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid this cycle
- command  out  8  decoded command
- address_0..address_5  out  8 each  decoded address bytes, in wire order
- sv_0, sv_1  out  8 each  decoded state-variable bytes
- data_0..data_3  out  8 each  decoded data bytes
- packet_valid  out  1  one-cycle pulse: all field outputs were updated from a good frame
- checksum_error  out  1  one-cycle pulse: frame complete but checksum mismatch
- framing_error  out  1  one-cycle pulse: malformed frame
- ack_rx  out  1  one-cycle pulse: ACK byte received while IDLE
- nak_rx  out  1  one-cycle pulse: NAK byte received while IDLE

Behaviour:
- Reset: state=IDLE, byte count=0, running XOR=0. All field outputs = 8'h00. All pulse outputs = 0.
- Only cycles with rx_valid=1 advance the FSM. Pulses deassert on every other cycle.
- Reserved set R = {STX, ETX, ACK, NAK, ESC}.
- IDLE:
  - STX -> BODY; count=0, xor=0.
  - ACK -> ack_rx pulse. NAK -> nak_rx pulse.
  - Any other byte is ignored.
- BODY:
  - ESC -> ESCAPE.
  - STX -> framing_error pulse, then restart: stay in BODY, count=0, xor=0.
  - ETX:
    - If count==BODY_BYTES+1 and the stored checksum equals the XOR of the BODY_BYTES decoded bytes: copy the shadow registers to the field outputs and pulse packet_valid.
    - If count==BODY_BYTES+1 and the checksum mismatches: pulse checksum_error.
    - If count differs from BODY_BYTES+1: pulse framing_error.
    - In every case -> IDLE.
  - ACK or NAK -> framing_error pulse, -> IDLE.
  - Other byte b -> store decoded byte b.
- ESCAPE:
  - Byte b with (b - 8'h80) in R -> store decoded byte (b - 8'h80), -> BODY.
  - Any other byte -> framing_error pulse, -> IDLE.
- Store decoded byte d:
  - If count < BODY_BYTES: shadow[count]=d, xor ^= d, count++.
  - If count == BODY_BYTES: checksum register = d, count++.
  - If count == BODY_BYTES+1: framing_error pulse (overlong frame), -> IDLE.
- Latency: the pulse is registered and asserts in the cycle after the terminating byte is sampled.
- Field outputs change only on packet_valid and hold until the next good frame. A bad frame never corrupts them.
- reset asserted mid-frame: back to IDLE next edge, outputs cleared, no pulse.
- Count width is 4 bits (max 14). Subtraction and XOR are 8-bit, modulo 256.

Decomposition:
- Package soundweb_pkg holds STX/ETX/ESC/ACK/NAK constants, the field index constants (COMMAND=0 … DATA_3=12), the escape offset 8'h80 and the is_reserved_byte function. The encoder is to be moved onto the same package.
- FSM state enum (IDLE, BODY, ESCAPE) is local to the module.
- No sub-module. A single FSM plus a shadow register file is natural.

Test Plan:
- Plain frame: 02 8D 00 00 00 00 00 00 00 00 00 00 00 10 9D 03 -> packet_valid one cycle after 03; command=8D, data_3=10, all other fields 00; no error pulses.
- Escaped frame: 02 88 00 01 1B 82 1B 83 04 05 00 00 00 00 01 00 88 03 -> packet_valid; address_0..5=00,01,02,03,04,05; data_2=01; command=88.
- Bad checksum: first frame with checksum byte 9C instead of 9D -> checksum_error pulse, no packet_valid, outputs retain previous values.
- Framing faults, each followed by a good frame that must decode:
  - Short frame: 02 8D 03 -> framing_error.
  - Bad escape: 02 8D 1B 41 -> framing_error.
  - STX mid-frame: 02 8D 00 02 followed by a full good frame -> framing_error on the second 02, then packet_valid.
- Idle control bytes: 06, then 15, then 55 -> ack_rx pulse, nak_rx pulse, nothing for 55. rx_valid gaps of 3 cycles between bytes of the escaped frame -> identical decode.
- Reset mid-frame: assert reset after the 6th byte of the plain frame, then send the full frame -> no pulse before reset, then normal packet_valid.
